// File: rtl/noise_lfsr_src.sv
// Pseudo-random noise source: 31-bit LFSR sampled by a programmable rate divider.
// Define NOISE_TRI_EN to add a second 29-bit LFSR and emit triangular-distributed samples.
module noise_lfsr_src #(
    parameter int unsigned dsz   = 18,
    parameter int unsigned DIVW  = 16,
    parameter logic [30:0] SEED  = 31'h0000_0001,
    parameter logic [28:0] SEED2 = 29'h0000_0001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIVW-1:0]       div,
    output logic                  strobe,
    output logic signed [dsz-1:0] out
);

    logic [30:0]           lfsr_q, lfsr_d;
    logic [DIVW-1:0]       cnt_q, cnt_d;
    logic                  strobe_q, strobe_d;
    logic signed [dsz-1:0] out_q, out_d;
    logic signed [dsz-1:0] sample;
    logic                  reload;

    assign reload = (cnt_q == '0);

    // x^31 + x^28 + 1; the all-zero state is forced back into the sequence.
    always_comb begin
        if (lfsr_q == '0) begin
            lfsr_d = 31'd1;
        end else begin
            lfsr_d = {lfsr_q[29:0], lfsr_q[30] ^ lfsr_q[27]};
        end
    end

`ifdef NOISE_TRI_EN
    logic [28:0]           lfsr2_q, lfsr2_d;
    logic signed [dsz-1:0] slice_a, slice_b;

    // x^29 + x^27 + 1 with the same lock-up guard.
    always_comb begin
        if (lfsr2_q == '0) begin
            lfsr2_d = 29'd1;
        end else begin
            lfsr2_d = {lfsr2_q[27:0], lfsr2_q[28] ^ lfsr2_q[26]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr2_q <= SEED2;
        end else begin
            lfsr2_q <= lfsr2_d;
        end
    end

    assign slice_a = lfsr_q[30 -: dsz];
    assign slice_b = lfsr2_q[28 -: dsz];
    // Halving both operands first keeps the sum inside the dsz-bit range.
    assign sample  = (slice_a >>> 1) + (slice_b >>> 1);
`else
    assign sample = lfsr_q[30 -: dsz];
`endif

    // div is only looked at on reload, so a mid-period change waits for the next period.
    always_comb begin
        cnt_d    = cnt_q - DIVW'(1);
        strobe_d = 1'b0;
        out_d    = out_q;
        if (reload) begin
            cnt_d    = div;
            strobe_d = 1'b1;
            out_d    = sample;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q   <= SEED;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            out_q    <= '0;
        end else begin
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            out_q    <= out_d;
        end
    end

    assign strobe = strobe_q;
    assign out    = out_q;

endmodule
